zpu_sd_sequencer: RTL and testbench
===================================

Name: zpu_sd_sequencer

Overview:
- Sequences multi-sector SD block transfers between the ZPU register interface and the hps_io sd_* handshake.
- Owns sector-buffer port B addressing with auto-increment, LBA stepping, per-sector CPU pacing, completion status and ack timeout.
- Sits in clk_sys between the ZPU_OUT2/ZPU_WR/ZPU_RD decode and the 512-byte dpram sector buffer / hps_io SD port.

Parameters:
TIMEOUT_W, 24, width of ack-wait counter; timeout fires when the counter reaches all-ones (2^TIMEOUT_W-1 cycles).
ADDR_W, 9, sector buffer address width (512 bytes).

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_lba_wr  in  1  1-cycle pulse: load start LBA from cmd_data
cmd_data  in  32  LBA value
cmd_count  in  8  sectors to transfer, sampled at start; 0 = no transfer
cmd_rd  in  1  1-cycle pulse: start read (SD to buffer)
cmd_wr  in  1  1-cycle pulse: start write (buffer to SD)
cmd_next  in  1  1-cycle pulse: CPU finished with buffer, continue
cmd_abort  in  1  1-cycle pulse: abandon remaining sectors
buf_rst  in  1  pulse: buffer pointer to 0
buf_data_wr  in  1  pulse: CPU byte write at pointer, then pointer+1
buf_data_rd  in  1  pulse: CPU read at pointer complete, then pointer+1
buf_addr  out  ADDR_W  dpram port B address
buf_we  out  1  dpram port B write enable
sd_lba  out  32  LBA presented to hps_io
sd_rd  out  1  read request
sd_wr  out  1  write request
sd_ack  in  1  hps_io acknowledge, high for the duration of the transfer
busy  out  1  transfer in progress (any state except IDLE)
sector_ready  out  1  high in SECT_WAIT
done  out  1  sticky, set on completion/abort/timeout; cleared on next start
timeout_err  out  1  sticky; cleared on next start
sectors_left  out  8  remaining sectors including the current one

Behaviour:
- Reset values: state IDLE; all outputs 0, including sd_lba, buf_addr and sectors_left. Reset applied mid-transfer drops sd_rd/sd_wr at the same edge. No wait for sd_ack.
- States: IDLE, REQ, XFER, SECT_WAIT.
- IDLE:
  - cmd_lba_wr loads sd_lba from cmd_data.
  - cmd_rd or cmd_wr latches direction (rd wins if both), loads sectors_left from cmd_count, and clears done and timeout_err.
  - If cmd_count is 0: stay IDLE and set done on the next edge.
  - Otherwise go to REQ, with buf_addr set to 0 and the timeout counter cleared.
- REQ:
  - sd_rd or sd_wr (per direction) is registered high in the cycle after the start edge.
  - sd_ack high: drop the request on that edge, go to XFER.
  - Counter reaches all-ones: drop the request, set timeout_err and done, go to IDLE.
- XFER: on the first cycle with sd_ack low, decrement sectors_left.
  - If the new value is 0: go to IDLE, set done.
  - Otherwise go to SECT_WAIT.
- SECT_WAIT (sector_ready=1):
  - cmd_next: sd_lba+1 (32-bit wrap), buf_addr to 0, counter cleared, go to REQ.
  - cmd_abort: set done, go to IDLE with sectors_left kept.
  - If both arrive in the same cycle, abort wins.
- sd_lba is not incremented after the final sector; it holds the last transferred LBA.
- cmd_lba_wr, cmd_rd and cmd_wr are ignored when busy. cmd_next and cmd_abort are ignored outside SECT_WAIT.
- Buffer pointer:
  - CPU ops (buf_rst, buf_data_wr, buf_data_rd) are accepted only in IDLE and SECT_WAIT; ignored in REQ/XFER, where hps owns the buffer.
  - Priority within one cycle: buf_rst > buf_data_wr > buf_data_rd.
  - buf_data_wr asserts buf_we for one cycle at the current address; the address increments on the following edge.
  - buf_data_rd increments on its edge.
  - 511+1 wraps to 0.
- Latency:
  - Start pulse to sd_rd: 1 edge.
  - sd_ack rise to request drop: 1 edge.
  - sd_ack fall to sector_ready/done: 1 edge.

Test Plan:
- cmd_lba_wr data=0x00001000, cmd_count=1, cmd_rd; ack high 3 cycles after sd_rd, 10 cycles long. Required: sd_rd drops 1 edge after ack rise; done=1, busy=0, sd_lba=0x1000, sectors_left=0.
- cmd_count=3 write at LBA 0x20, cmd_next in each SECT_WAIT. Required: sd_wr asserted 3 times at LBAs 0x20/0x21/0x22; sector_ready pulses twice; done after the third sector.
- Never assert ack, TIMEOUT_W=4. Required: sd_rd high exactly 15 cycles, then 0; timeout_err=1, done=1, busy=0.
- In IDLE: 512 buf_data_wr pulses. Required: buf_addr 0..511 then 0, buf_we=1 for each. buf_data_wr during XFER: buf_addr and buf_we unchanged.
- cmd_count=4, cmd_abort plus cmd_next in the same cycle in the first SECT_WAIT. Required: IDLE, done=1, sectors_left=3, no further sd_rd.
- Assert reset while sd_rd=1 in REQ. Required: next edge sd_rd=0 and all outputs 0. A subsequent cmd_rd with count=0 gives done=1 after 1 edge, with no request issued.

Source files
------------

// File: rtl/zpu_sd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : zpu_sd_sequencer
//  Purpose  : Multi-sector SD block transfer sequencer between the ZPU
//             register interface and the hps_io sd_* handshake. Owns the
//             sector-buffer port B pointer, LBA stepping, per-sector CPU
//             pacing, completion status and the ack-wait timeout.
//  Revision : 1.0  initial release
// ============================================================================
module zpu_sd_sequencer #(
  parameter int TIMEOUT_W = 24,
  parameter int ADDR_W    = 9
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cmd_lba_wr,
  input  logic [31:0]       cmd_data,
  input  logic [7:0]        cmd_count,
  input  logic              cmd_rd,
  input  logic              cmd_wr,
  input  logic              cmd_next,
  input  logic              cmd_abort,
  input  logic              buf_rst,
  input  logic              buf_data_wr,
  input  logic              buf_data_rd,
  output logic [ADDR_W-1:0] buf_addr,
  output logic              buf_we,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  output logic              busy,
  output logic              sector_ready,
  output logic              done,
  output logic              timeout_err,
  output logic [7:0]        sectors_left
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_XFER      = 2'd2,
    S_SECT_WAIT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                dir_rd_q, dir_rd_d;
  logic [7:0]          left_q, left_d;
  logic [31:0]         lba_q, lba_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                done_q, done_d;
  logic                terr_q, terr_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  logic [TIMEOUT_W-1:0] cnt_inc;
  logic [ADDR_W-1:0]    addr_base;

  // Next-state, request and buffer-pointer logic
  always_comb begin
    state_d  = state_q;
    dir_rd_d = dir_rd_q;
    left_d   = left_q;
    lba_d    = lba_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    rd_d     = rd_q;
    wr_d     = wr_q;
    done_d   = done_q;
    terr_d   = terr_q;
    cnt_d    = cnt_q;
    cnt_inc  = cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    // A write strobe holds the address for its cycle; the step lands one edge later.
    addr_base = addr_q + {{(ADDR_W-1){1'b0}}, we_q};

    // CPU owns the buffer pointer only while hps is not transferring.
    if (state_q == S_IDLE || state_q == S_SECT_WAIT) begin
      addr_d = addr_base;
      if (buf_rst) begin
        addr_d = '0;
      end else if (buf_data_wr) begin
        we_d = 1'b1;
      end else if (buf_data_rd) begin
        addr_d = addr_base + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_lba_wr) begin
          lba_d = cmd_data;
        end
        if (cmd_rd || cmd_wr) begin
          dir_rd_d = cmd_rd;
          left_d   = cmd_count;
          done_d   = 1'b0;
          terr_d   = 1'b0;
          if (cmd_count == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_REQ;
            addr_d  = '0;
            we_d    = 1'b0;
            cnt_d   = '0;
            rd_d    = cmd_rd;
            wr_d    = ~cmd_rd;
          end
        end
      end
      S_REQ: begin
        if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_XFER;
        end else if (&cnt_inc) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          terr_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_XFER: begin
        if (!sd_ack) begin
          left_d = left_q - 8'd1;
          if (left_q == 8'd1) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_SECT_WAIT;
          end
        end
      end
      S_SECT_WAIT: begin
        if (cmd_abort) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cmd_next) begin
          lba_d   = lba_q + 32'd1;
          addr_d  = '0;
          we_d    = 1'b0;
          cnt_d   = '0;
          rd_d    = dir_rd_q;
          wr_d    = ~dir_rd_q;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= S_IDLE;
      dir_rd_q <= 1'b0;
      left_q   <= 8'd0;
      lba_q    <= 32'd0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dir_rd_q <= dir_rd_d;
      left_q   <= left_d;
      lba_q    <= lba_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      done_q   <= done_d;
      terr_q   <= terr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign buf_addr     = addr_q;
  assign buf_we       = we_q;
  assign sd_lba       = lba_q;
  assign sd_rd        = rd_q;
  assign sd_wr        = wr_q;
  assign busy         = (state_q != S_IDLE);
  assign sector_ready = (state_q == S_SECT_WAIT);
  assign done         = done_q;
  assign timeout_err  = terr_q;
  assign sectors_left = left_q;

endmodule
`default_nettype wire

// File: tb/tb_zpu_sd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zpu_sd_sequencer
//  Purpose  : Self-checking bench for zpu_sd_sequencer. A transaction-level
//             model pushes the expected request / sector / completion events
//             into a scoreboard queue; a monitor pops them as the DUT shows
//             them. Buffer-pointer behaviour is checked against a pointer model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_zpu_sd_sequencer;

  localparam int TW = 4;
  localparam int AW = 9;
  localparam int EV_REQ  = 0;
  localparam int EV_SECT = 1;
  localparam int EV_END  = 2;

  typedef struct {
    int          kind;
    logic        dir_rd;
    logic [31:0] lba;
    logic [7:0]  left;
    logic        terr;
  } ev_t;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_lba_wr = 1'b0;
  logic [31:0]   cmd_data = '0;
  logic [7:0]    cmd_count = '0;
  logic          cmd_rd = 1'b0, cmd_wr = 1'b0, cmd_next = 1'b0, cmd_abort = 1'b0;
  logic          buf_rst = 1'b0, buf_data_wr = 1'b0, buf_data_rd = 1'b0;
  logic [AW-1:0] buf_addr;
  logic          buf_we;
  logic [31:0]   sd_lba;
  logic          sd_rd, sd_wr;
  logic          sd_ack = 1'b0;
  logic          busy, sector_ready, done, timeout_err;
  logic [7:0]    sectors_left;

  int  checks = 0;
  int  errors = 0;
  ev_t sb[$];
  logic mon_en = 1'b0;

  zpu_sd_sequencer #(.TIMEOUT_W(TW), .ADDR_W(AW)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .cmd_lba_wr(cmd_lba_wr), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .cmd_rd(cmd_rd), .cmd_wr(cmd_wr), .cmd_next(cmd_next), .cmd_abort(cmd_abort),
    .buf_rst(buf_rst), .buf_data_wr(buf_data_wr), .buf_data_rd(buf_data_rd),
    .buf_addr(buf_addr), .buf_we(buf_we),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .busy(busy), .sector_ready(sector_ready), .done(done),
    .timeout_err(timeout_err), .sectors_left(sectors_left)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic dir_rd, input logic [31:0] lba,
                         input logic [7:0] left, input logic terr);
    ev_t e;
    e.kind = kind; e.dir_rd = dir_rd; e.lba = lba; e.left = left; e.terr = terr;
    sb.push_back(e);
  endtask

  // Monitor: pops an expected event whenever the DUT presents one.
  logic req_prev = 1'b0, sr_prev = 1'b0, busy_prev = 1'b0;
  ev_t  mev;
  always @(negedge clk_sys) begin
    if (mon_en) begin
      if ((sd_rd | sd_wr) && !req_prev) begin
        if (sb.size() == 0) check("unexpected_request", 32'd1, 32'd0);
        else begin
          mev = sb.pop_front();
          check("req_kind", 32'(EV_REQ), 32'(mev.kind));
          check("req_sd_rd", 32'(sd_rd), 32'(mev.dir_rd));
          check("req_sd_wr", 32'(sd_wr), 32'(!mev.dir_rd));
          check("req_lba", sd_lba, mev.lba);
        end
      end
      if (sector_ready && !sr_prev) begin
        if (sb.size() == 0) check("unexpected_sector_ready", 32'd1, 32'd0);
        else begin
          mev = sb.pop_front();
          check("sect_kind", 32'(EV_SECT), 32'(mev.kind));
          check("sect_left", 32'(sectors_left), 32'(mev.left));
          check("sect_busy", 32'(busy), 32'd1);
        end
      end
      if (!busy && busy_prev) begin
        if (sb.size() == 0) check("unexpected_end", 32'd1, 32'd0);
        else begin
          mev = sb.pop_front();
          check("end_kind", 32'(EV_END), 32'(mev.kind));
          check("end_done", 32'(done), 32'd1);
          check("end_timeout_err", 32'(timeout_err), 32'(mev.terr));
          check("end_left", 32'(sectors_left), 32'(mev.left));
          check("end_lba", sd_lba, mev.lba);
          check("end_req_low", 32'(sd_rd | sd_wr), 32'd0);
        end
      end
    end
    req_prev  <= sd_rd | sd_wr;
    sr_prev   <= sector_ready;
    busy_prev <= busy;
  end

  // One complete command. ab/tmo give the sector index that is aborted / never acked (-1 none).
  task automatic run_xfer(input logic rd, input logic both, input logic [31:0] lba, input int n,
                          input int ab, input logic ab_next, input int tmo,
                          input int ack_d, input int ack_l);
    int hi;
    int k;
    // Transaction-level expectation
    for (int i = 0; i < n; i++) begin
      push_ev(EV_REQ, rd, lba + 32'(i), 8'd0, 1'b0);
      if (i == tmo) begin push_ev(EV_END, rd, lba + 32'(i), 8'(n - i), 1'b1); break; end
      if (i == n - 1) begin push_ev(EV_END, rd, lba + 32'(i), 8'd0, 1'b0); break; end
      push_ev(EV_SECT, rd, 32'd0, 8'(n - i - 1), 1'b0);
      if (i == ab) begin push_ev(EV_END, rd, lba + 32'(i), 8'(n - i - 1), 1'b0); break; end
    end
    cmd_lba_wr = 1'b1; cmd_data = lba;
    @(negedge clk_sys);
    cmd_lba_wr = 1'b0;
    cmd_count = 8'(n); cmd_rd = rd | both; cmd_wr = ~rd | both;
    @(negedge clk_sys);
    cmd_rd = 1'b0; cmd_wr = 1'b0;
    if (n == 0) begin
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy", 32'(busy), 32'd0);
      check("zero_terr", 32'(timeout_err), 32'd0);
      check("zero_req", 32'(sd_rd | sd_wr), 32'd0);
      return;
    end
    check("start_latency", 32'(sd_rd | sd_wr), 32'd1);
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (!(sd_rd | sd_wr) && k < 10) begin @(negedge clk_sys); k++; end
      if (k == 10) begin check("req_wait_expired", 32'd1, 32'd0); return; end
      if (i == tmo) begin
        hi = 0;
        while ((sd_rd | sd_wr) && hi < 40) begin hi++; @(negedge clk_sys); end
        check("timeout_req_cycles", 32'(hi), 32'((1 << TW) - 1));
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_flag", 32'(timeout_err), 32'd1);
        return;
      end
      repeat (ack_d) @(negedge clk_sys);
      sd_ack = 1'b1;
      @(negedge clk_sys);
      check("ack_to_drop", 32'(sd_rd | sd_wr), 32'd0);
      buf_data_wr = 1'b1; buf_data_rd = 1'b1;
      @(negedge clk_sys);
      buf_data_wr = 1'b0; buf_data_rd = 1'b0;
      check("xfer_buf_addr", 32'(buf_addr), 32'd0);
      check("xfer_buf_we", 32'(buf_we), 32'd0);
      repeat (ack_l) @(negedge clk_sys);
      sd_ack = 1'b0;
      @(negedge clk_sys);
      if (i == n - 1) begin
        check("last_done", 32'(done), 32'd1);
        return;
      end
      check("sector_ready", 32'(sector_ready), 32'd1);
      if (i == ab) begin
        cmd_abort = 1'b1; cmd_next = ab_next;
        @(negedge clk_sys);
        cmd_abort = 1'b0; cmd_next = 1'b0;
        repeat (4) @(negedge clk_sys);
        check("abort_no_req", 32'(sd_rd | sd_wr), 32'd0);
        return;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk_sys);
      cmd_next = 1'b1;
      @(negedge clk_sys);
      cmd_next = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin @(negedge clk_sys); k++; end
    if (k == 100) check("idle_wait_expired", 32'd1, 32'd0);
    repeat (2) @(negedge clk_sys);
  endtask

  initial begin
    int ptr;
    int op;
    logic [AW-1:0] exp_addr;
    logic exp_we;

    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    check("rst_buf_addr", 32'(buf_addr), 32'd0);
    check("rst_buf_we", 32'(buf_we), 32'd0);
    check("rst_sd_lba", sd_lba, 32'd0);
    check("rst_sd_rd", 32'(sd_rd), 32'd0);
    check("rst_sd_wr", 32'(sd_wr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sector_ready", 32'(sector_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_sectors_left", 32'(sectors_left), 32'd0);
    mon_en = 1'b1;

    // Directed transfers
    run_xfer(1'b1, 1'b0, 32'h0000_1000, 1, -1, 1'b0, -1, 3, 8);  wait_idle();
    run_xfer(1'b0, 1'b0, 32'h0000_0020, 3, -1, 1'b0, -1, 2, 3);  wait_idle();
    run_xfer(1'b1, 1'b0, 32'h0000_0077, 2, -1, 1'b0, 0, 0, 0);   wait_idle();
    run_xfer(1'b1, 1'b0, 32'h0000_0100, 4, 0, 1'b1, -1, 1, 2);   wait_idle();
    run_xfer(1'b1, 1'b1, 32'hFFFF_FFFF, 2, -1, 1'b0, -1, 0, 1);  wait_idle();

    // Buffer pointer: 512 back-to-back writes then wrap
    buf_rst = 1'b1;
    @(negedge clk_sys);
    buf_rst = 1'b0;
    check("bufrst_addr", 32'(buf_addr), 32'd0);
    for (int i = 0; i < 512; i++) begin
      buf_data_wr = 1'b1;
      @(negedge clk_sys);
      check("wr_seq_addr", 32'(buf_addr), 32'(i));
      check("wr_seq_we", 32'(buf_we), 32'd1);
    end
    buf_data_wr = 1'b0;
    @(negedge clk_sys);
    check("wr_wrap_addr", 32'(buf_addr), 32'd0);
    check("wr_wrap_we", 32'(buf_we), 32'd0);

    // Random buffer ops against a next-address pointer model
    ptr = 0;
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 15));
      buf_rst = (op == 0); buf_data_wr = op[1]; buf_data_rd = op[2];
      @(negedge clk_sys);
      if (buf_rst) begin ptr = 0; exp_addr = '0; exp_we = 1'b0; end
      else if (buf_data_wr) begin exp_addr = AW'(ptr); exp_we = 1'b1; ptr = (ptr + 1) % 512; end
      else if (buf_data_rd) begin ptr = (ptr + 1) % 512; exp_addr = AW'(ptr); exp_we = 1'b0; end
      else begin exp_addr = AW'(ptr); exp_we = 1'b0; end
      check("rnd_buf_addr", 32'(buf_addr), 32'(exp_addr));
      check("rnd_buf_we", 32'(buf_we), 32'(exp_we));
    end
    buf_rst = 1'b0; buf_data_wr = 1'b0; buf_data_rd = 1'b0;
    @(negedge clk_sys);

    // Randomized transactions
    for (int t = 0; t < 25; t++) begin
      int n, ab, tmo;
      logic rd;
      n   = int'($urandom_range(0, 5));
      rd  = 1'($urandom_range(0, 1));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      tmo = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_xfer(rd, rd & 1'($urandom_range(0, 1)),
               ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFE : $urandom,
               n, ab, 1'($urandom_range(0, 1)), tmo,
               int'($urandom_range(0, 8)), int'($urandom_range(0, 6)));
      wait_idle();
    end

    // Reset during an outstanding request
    mon_en = 1'b0;
    cmd_count = 8'd2; cmd_rd = 1'b1;
    @(negedge clk_sys);
    cmd_rd = 1'b0;
    check("mid_req_high", 32'(sd_rd), 32'd1);
    reset = 1'b1;
    @(negedge clk_sys);
    check("mid_rst_sd_rd", 32'(sd_rd), 32'd0);
    check("mid_rst_sd_wr", 32'(sd_wr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_terr", 32'(timeout_err), 32'd0);
    check("mid_rst_lba", sd_lba, 32'd0);
    check("mid_rst_addr", 32'(buf_addr), 32'd0);
    check("mid_rst_left", 32'(sectors_left), 32'd0);
    check("mid_rst_sr", 32'(sector_ready), 32'd0);
    reset = 1'b0;
    cmd_count = 8'd0; cmd_rd = 1'b1;
    @(negedge clk_sys);
    cmd_rd = 1'b0;
    check("post_rst_zero_done", 32'(done), 32'd1);
    check("post_rst_zero_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk_sys);
    check("post_rst_no_req", 32'(sd_rd | sd_wr), 32'd0);
    mon_en = 1'b1;

    repeat (3) @(negedge clk_sys);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
